seven_segment_monitor: RTL and testbench

- Receive-side counterpart of the team's seconds counter and seven-segment encoder. Samples a 7-bit segment bus, filters glitches, and decodes stable patterns back to a 4-bit digit.
- Checks that successive digits follow the expected modulo count and measures the period between digit changes.
- Used in test designs to self-check a seven-segment driver, with results observable via scan.

---
 rtl/seven_segment_monitor.sv | 211 +++++++++++++++++++++
 tb/tb_seven_segment_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_monitor.sv
// ---------------------------------------------------------------------------
// seven_segment_monitor
//
// Receive-side checker for a seven-segment driver. The segment bus is
// sampled every enabled cycle and a pattern is accepted once it has been
// seen for STABLE_CYCLES consecutive samples. Each accepted pattern that
// differs from the previous one is decoded back to a digit. The block then
// checks that the digit is the modulo successor of the previous digit and
// measures the number of cycles between successive valid digits.
//
// Optional feature: define SEG7_MON_HEX_EN to decode the A-F patterns as
// valid digits 10-15. Without the macro those patterns are undecodable and
// the decode logic for them is not built.
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples needed to accept (2..255)
//   MAX_DIGIT      last digit before the expected wrap to 0 (1..15)
//   CNT_W          width of the period measurement counter
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset, priority over ena
//   ena            enable; low freezes every register
//   seg_in[6:0]    segment bus, bit0 = segment a ... bit6 = segment g
//   digit[3:0]     last accepted decoded digit
//   digit_valid    one-cycle pulse on each accepted valid digit
//   invalid_err    sticky; an accepted pattern was not decodable
//   seq_err        sticky; an accepted digit was not the expected successor
//   seq_err_count  number of sequence errors, saturating at 255
//   period         cycles between the last two accepted valid digits
// ---------------------------------------------------------------------------
module seven_segment_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_DIGIT     = 9,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             invalid_err,
  output logic             seq_err,
  output logic [7:0]       seq_err_count,
  output logic [CNT_W-1:0] period
);

  localparam logic [7:0] STAB    = 8'(STABLE_CYCLES);
  localparam logic [3:0] MAX_DIG = 4'(MAX_DIGIT);

  typedef enum logic {
    IDLE,
    TRACK
  } stateT;

  stateT            state_q, state_d;
  logic [6:0]       segSample_q, segSample_d;
  logic [6:0]       cand_q, cand_d;
  logic [6:0]       lastPat_q, lastPat_d;
  logic [7:0]       stableCnt_q, stableCnt_d;
  logic [CNT_W-1:0] periodCnt_q, periodCnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [3:0]       digit_q, digit_d;
  logic             digitValid_q, digitValid_d;
  logic             invalidErr_q, invalidErr_d;
  logic             seqErr_q, seqErr_d;
  logic [7:0]       seqErrCount_q, seqErrCount_d;

  logic [3:0]       decDigit;
  logic             decValid;
  logic             decBlank;
  logic [3:0]       expDigit;
  logic             accept;

  // Pattern decoder working on the stable candidate. Blank is recognised
  // separately because it is accepted silently rather than as an error.
  always_comb begin
    decDigit = 4'd0;
    decValid = 1'b0;
    decBlank = (cand_q == 7'h00);
    case (cand_q)
      7'h3F: begin decDigit = 4'd0; decValid = 1'b1; end
      7'h06: begin decDigit = 4'd1; decValid = 1'b1; end
      7'h5B: begin decDigit = 4'd2; decValid = 1'b1; end
      7'h4F: begin decDigit = 4'd3; decValid = 1'b1; end
      7'h66: begin decDigit = 4'd4; decValid = 1'b1; end
      7'h6D: begin decDigit = 4'd5; decValid = 1'b1; end
      7'h7D: begin decDigit = 4'd6; decValid = 1'b1; end
      7'h07: begin decDigit = 4'd7; decValid = 1'b1; end
      7'h7F: begin decDigit = 4'd8; decValid = 1'b1; end
      7'h6F: begin decDigit = 4'd9; decValid = 1'b1; end
`ifdef SEG7_MON_HEX_EN
      7'h77: begin decDigit = 4'd10; decValid = 1'b1; end
      7'h7C: begin decDigit = 4'd11; decValid = 1'b1; end
      7'h39: begin decDigit = 4'd12; decValid = 1'b1; end
      7'h5E: begin decDigit = 4'd13; decValid = 1'b1; end
      7'h79: begin decDigit = 4'd14; decValid = 1'b1; end
      7'h71: begin decDigit = 4'd15; decValid = 1'b1; end
`endif
      default: begin
        decDigit = 4'd0;
        decValid = 1'b0;
      end
    endcase
  end

  // Expected successor of the last valid digit, wrapping after MAX_DIGIT.
  assign expDigit = (digit_q == MAX_DIG) ? 4'd0 : digit_q + 4'd1;

  // A pattern is accepted on the sample that completes the stability run,
  // and only if it differs from the previously accepted one. The counter
  // then saturates, so a held pattern is never accepted twice.
  assign accept = (segSample_q == cand_q) && (stableCnt_q == STAB - 8'd1) &&
                  (cand_q != lastPat_q);

  // Next-state logic: input filter, FSM, sequence check and period
  // measurement. Every register holds its value unless changed below.
  always_comb begin
    state_d       = state_q;
    segSample_d   = seg_in;
    cand_d        = cand_q;
    lastPat_d     = lastPat_q;
    stableCnt_d   = stableCnt_q;
    periodCnt_d   = periodCnt_q;
    period_d      = period_q;
    digit_d       = digit_q;
    digitValid_d  = 1'b0;
    invalidErr_d  = invalidErr_q;
    seqErr_d      = seqErr_q;
    seqErrCount_d = seqErrCount_q;

    if (segSample_q != cand_q) begin
      cand_d      = segSample_q;
      stableCnt_d = 8'd1;
    end else if (stableCnt_q != STAB) begin
      stableCnt_d = stableCnt_q + 8'd1;
    end

    if ((state_q == TRACK) && (periodCnt_q != '1)) begin
      periodCnt_d = periodCnt_q + 1'b1;
    end

    if (accept) begin
      lastPat_d = cand_q;
      if (decBlank) begin
        lastPat_d = cand_q;
      end else if (!decValid) begin
        invalidErr_d = 1'b1;
      end else begin
        digit_d      = decDigit;
        digitValid_d = 1'b1;
        periodCnt_d  = '0;
        if (state_q == IDLE) begin
          state_d = TRACK;
        end else begin
          // Digits above MAX_DIGIT can never be a legal successor.
          if ((decDigit > MAX_DIG) || (decDigit != expDigit)) begin
            seqErr_d = 1'b1;
            if (seqErrCount_q != 8'hFF) begin
              seqErrCount_d = seqErrCount_q + 8'd1;
            end
          end
          period_d = (periodCnt_q == '1) ? periodCnt_q : periodCnt_q + 1'b1;
        end
      end
    end
  end

  // State registers. Reset wins over enable; a low enable freezes
  // everything, including the input sampler.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      segSample_q   <= 7'h00;
      cand_q        <= 7'h00;
      lastPat_q     <= 7'h00;
      stableCnt_q   <= 8'd0;
      periodCnt_q   <= '0;
      period_q      <= '0;
      digit_q       <= 4'd0;
      digitValid_q  <= 1'b0;
      invalidErr_q  <= 1'b0;
      seqErr_q      <= 1'b0;
      seqErrCount_q <= 8'd0;
    end else if (ena) begin
      state_q       <= state_d;
      segSample_q   <= segSample_d;
      cand_q        <= cand_d;
      lastPat_q     <= lastPat_d;
      stableCnt_q   <= stableCnt_d;
      periodCnt_q   <= periodCnt_d;
      period_q      <= period_d;
      digit_q       <= digit_d;
      digitValid_q  <= digitValid_d;
      invalidErr_q  <= invalidErr_d;
      seqErr_q      <= seqErr_d;
      seqErrCount_q <= seqErrCount_d;
    end
  end

  // The pulse register is frozen along with everything else while ena is
  // low, so the output is masked to avoid a stretched pulse.
  assign digit_valid   = digitValid_q & ena;
  assign digit         = digit_q;
  assign invalid_err   = invalidErr_q;
  assign seq_err       = seqErr_q;
  assign seq_err_count = seqErrCount_q;
  assign period        = period_q;

endmodule

// File: tb/tb_seven_segment_monitor.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_monitor
//
// Scoreboard bench for seven_segment_monitor with default parameters
// (STABLE_CYCLES=4, MAX_DIGIT=9, CNT_W=16). The stimulus thread pushes the
// expected state for every digit_valid pulse it provokes; a monitor pops and
// compares on each pulse. Direct checks cover reset and non-pulse cases.
// ---------------------------------------------------------------------------
module tb_seven_segment_monitor;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [6:0]  seg_in;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        invalid_err;
  logic        seq_err;
  logic [7:0]  seq_err_count;
  logic [15:0] period;

  typedef struct {
    int digit;
    int seqErr;
    int seqCount;
    int period;
    int invErr;
  } expT;

  expT expQ[$];
  expT monExp;

  int checkCount = 0;
  int passCount  = 0;
  int lat;
  int hexCount;

  logic [6:0] segTab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seven_segment_monitor #(
    .STABLE_CYCLES(4),
    .MAX_DIGIT(9),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .seg_in(seg_in),
    .digit(digit),
    .digit_valid(digit_valid),
    .invalid_err(invalid_err),
    .seq_err(seq_err),
    .seq_err_count(seq_err_count),
    .period(period)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its expectation and keep the tallies.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive a pattern from a falling edge and hold it for a number of cycles.
  task automatic applyStimulus(input logic [6:0] pat, input int cycles);
    seg_in = pat;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pushExp(input int d, input int se, input int sc, input int per, input int ie);
    expT e;
    e.digit    = d;
    e.seqErr   = se;
    e.seqCount = sc;
    e.period   = per;
    e.invErr   = ie;
    expQ.push_back(e);
  endtask

  // Monitor: every digit_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && digit_valid) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpectedPulse: pulse with digit=%0d, expected no pulse", digit);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("pulseDigit", int'(digit), monExp.digit);
        checkOutput("pulseSeqErr", int'(seq_err), monExp.seqErr);
        checkOutput("pulseSeqCount", int'(seq_err_count), monExp.seqCount);
        checkOutput("pulsePeriod", int'(period), monExp.period);
        checkOutput("pulseInvalidErr", int'(invalid_err), monExp.invErr);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    seg_in = 7'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("resetDigit", int'(digit), 0);
    checkOutput("resetValid", int'(digit_valid), 0);
    checkOutput("resetInvalid", int'(invalid_err), 0);
    checkOutput("resetSeqErr", int'(seq_err), 0);
    checkOutput("resetSeqCount", int'(seq_err_count), 0);
    checkOutput("resetPeriod", int'(period), 0);

    // First digit after reset: pulse visible after the fifth edge.
    $display("[TB] counting sequence 0..9,0");
    pushExp(0, 0, 0, 0, 0);
    seg_in = 7'h3F;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (digit_valid && lat == 0) lat = i;
    end
    checkOutput("acceptLatency", lat, 5);
    repeat (990) @(negedge clk);

    for (int d = 1; d <= 10; d++) begin
      pushExp(d % 10, 0, 0, 1000, 0);
      applyStimulus(segTab[d % 10], 1000);
    end

    // Short glitch back to the held pattern must not be accepted.
    $display("[TB] glitch filtering");
    pushExp(1, 0, 0, 1000, 0);
    applyStimulus(7'h06, 1000);
    applyStimulus(7'h5B, 3);
    applyStimulus(7'h06, 97);
    checkOutput("glitchDigit", int'(digit), 1);

    // Skipped digit raises a sticky error; the next in-order digit does not.
    $display("[TB] sequence errors");
    pushExp(3, 1, 1, 1100, 0);
    applyStimulus(7'h4F, 500);
    pushExp(4, 1, 1, 500, 0);
    applyStimulus(7'h66, 300);
    pushExp(8, 1, 2, 300, 0);
    applyStimulus(7'h7F, 200);

    // Undecodable pattern.
    $display("[TB] undecodable patterns");
    applyStimulus(7'h23, 100);
    checkOutput("invalidSet", int'(invalid_err), 1);
    checkOutput("invalidDigitHeld", int'(digit), 8);

`ifdef SEG7_MON_HEX_EN
    pushExp(10, 1, 3, 300, 1);
    applyStimulus(7'h77, 100);
    checkOutput("hexDigit", int'(digit), 10);
    hexCount = 4;
    pushExp(9, 1, 4, 100, 1);
`else
    applyStimulus(7'h77, 100);
    checkOutput("hexDisabledDigit", int'(digit), 8);
    checkOutput("hexDisabledInvalid", int'(invalid_err), 1);
    hexCount = 2;
    pushExp(9, 1, 2, 400, 1);
`endif
    applyStimulus(7'h6F, 400);

    // Frozen cycles are excluded from the period measurement.
    $display("[TB] enable freeze");
    pushExp(0, 1, hexCount, 400, 1);
    applyStimulus(7'h3F, 100);
    ena = 1'b0;
    repeat (50) @(negedge clk);
    ena = 1'b1;
    repeat (100) @(negedge clk);
    pushExp(1, 1, hexCount, 200, 1);
    applyStimulus(7'h06, 20);

    // Reset in the middle of a stability run.
    $display("[TB] reset mid-operation");
    applyStimulus(7'h5B, 2);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midResetDigit", int'(digit), 0);
    checkOutput("midResetValid", int'(digit_valid), 0);
    checkOutput("midResetInvalid", int'(invalid_err), 0);
    checkOutput("midResetSeqErr", int'(seq_err), 0);
    checkOutput("midResetSeqCount", int'(seq_err_count), 0);
    checkOutput("midResetPeriod", int'(period), 0);
    seg_in = 7'h66;
    rst = 1'b0;
    pushExp(4, 0, 0, 0, 0);
    applyStimulus(7'h66, 20);

    repeat (5) @(negedge clk);
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
